// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with a valid/ready handshake and a two-entry skid
// buffer (main + skid), so execute can stall decode while in_ready stays a
// pure flop output with no combinational path from out_ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        decode-side handshake
//   flush                      synchronous flush; empties both entries
//   EX, M, WB                  control fields from decode
//   RsD, RtD, RdD              register specifiers from decode
//   RD1, DataB, SignImmD       operand words from decode
//   out_valid / out_ready      execute-side handshake
//   EX_E, M_E, WB_E            registered control fields (from main entry)
//   RsE, RtE, RdE              registered specifiers (from main entry)
//   RD1_E, DataB_E, SignImmE   registered operands (from main entry)
//   stall_cnt                  saturating count of out_valid && !out_ready
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int EX_W   = 4,
    parameter int M_W    = 3,
    parameter int WB_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [EX_W-1:0]   EX,
    input  logic [M_W-1:0]    M,
    input  logic [WB_W-1:0]   WB,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic [REG_W-1:0]  RdD,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] DataB,
    input  logic [DATA_W-1:0] SignImmD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EX_W-1:0]   EX_E,
    output logic [M_W-1:0]    M_E,
    output logic [WB_W-1:0]   WB_E,
    output logic [REG_W-1:0]  RsE,
    output logic [REG_W-1:0]  RtE,
    output logic [REG_W-1:0]  RdE,
    output logic [DATA_W-1:0] RD1_E,
    output logic [DATA_W-1:0] DataB_E,
    output logic [DATA_W-1:0] SignImmE,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = EX_W + M_W + WB_W + 3 * REG_W + 3 * DATA_W;

    // Encoding chosen so bit 0 is "main valid" and bit 1 is "skid valid":
    // out_valid and in_ready then come straight off state flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [PAY_W-1:0] main_q, main_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic [PAY_W-1:0] in_payload;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             push;
    logic             pop;

    // Control fields sit in the low bits of the payload.
    assign in_payload = {SignImmD, DataB, RD1, RdD, RtD, RsD, WB, M, EX};

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // State register and entry storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / next-contents
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Whole payload is cleared: a zero control word is the bubble,
            // and clearing data as well costs nothing extra here.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_d  = in_payload;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        skid_d  = in_payload;
                        state_d = ST_FULL;
                    end else if (push && pop) begin
                        main_d  = in_payload;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Stall counter saturates at all-ones; flush leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign {SignImmE, DataB_E, RD1_E, RdE, RtE, RsE, WB_E, M_E, EX_E} = main_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Randomised plus directed bench for id_ex_stage. A queue-based reference
// model (capacity-2 FIFO, unbounded stall tally) predicts every output each
// cycle. A second instance with CNT_W=3 checks counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic [3:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] datab;
        logic [31:0] imm;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic [3:0]  EX;
    logic [2:0]  M;
    logic [1:0]  WB;
    logic [4:0]  RsD, RtD, RdD;
    logic [31:0] RD1, DataB, SignImmD;

    logic        in_ready, out_valid;
    logic [3:0]  EX_E;
    logic [2:0]  M_E;
    logic [1:0]  WB_E;
    logic [4:0]  RsE, RtE, RdE;
    logic [31:0] RD1_E, DataB_E, SignImmE;
    logic [15:0] stall_cnt;

    logic        in_ready3, out_valid3;
    logic [3:0]  EX_E3;
    logic [2:0]  M_E3;
    logic [1:0]  WB_E3;
    logic [4:0]  RsE3, RtE3, RdE3;
    logic [31:0] RD1_E3, DataB_E3, SignImmE3;
    logic [2:0]  stall_cnt3;

    id_ex_stage u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .EX(EX), .M(M), .WB(WB), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .RD1(RD1), .DataB(DataB), .SignImmD(SignImmD), .out_valid(out_valid),
        .out_ready(out_ready), .EX_E(EX_E), .M_E(M_E), .WB_E(WB_E), .RsE(RsE),
        .RtE(RtE), .RdE(RdE), .RD1_E(RD1_E), .DataB_E(DataB_E),
        .SignImmE(SignImmE), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.CNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .flush(flush), .EX(EX), .M(M), .WB(WB), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .RD1(RD1), .DataB(DataB), .SignImmD(SignImmD), .out_valid(out_valid3),
        .out_ready(out_ready), .EX_E(EX_E3), .M_E(M_E3), .WB_E(WB_E3), .RsE(RsE3),
        .RtE(RtE3), .RdE(RdE3), .RD1_E(RD1_E3), .DataB_E(DataB_E3),
        .SignImmE(SignImmE3), .stall_cnt(stall_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    beat_t mq[$];
    int    stall_total;
    bit    zero_all;   // since reset and no push: every output field is 0
    bit    zero_ctl;   // since flush and no push: control fields are 0
    bit    verbose;

    int n_tests;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        beat_t e;
        int    s16;
        int    s3;
        check_eq("in_ready", in_ready, mq.size() < 2);
        check_eq("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            e = mq[0];
            check_eq("EX_E", EX_E, e.ex);
            check_eq("M_E", M_E, e.m);
            check_eq("WB_E", WB_E, e.wb);
            check_eq("RsE", RsE, e.rs);
            check_eq("RtE", RtE, e.rt);
            check_eq("RdE", RdE, e.rd);
            check_eq("RD1_E", RD1_E, e.rd1);
            check_eq("DataB_E", DataB_E, e.datab);
            check_eq("SignImmE", SignImmE, e.imm);
        end else if (zero_all) begin
            check_eq("rst_ctl", {EX_E, M_E, WB_E}, 0);
            check_eq("rst_regs", {RsE, RtE, RdE}, 0);
            check_eq("rst_data", {RD1_E, DataB_E}, 0);
            check_eq("rst_imm", SignImmE, 0);
        end else if (zero_ctl) begin
            check_eq("bubble_ctl", {EX_E, M_E, WB_E}, 0);
        end
        s16 = (stall_total > 65535) ? 65535 : stall_total;
        s3  = (stall_total > 7) ? 7 : stall_total;
        check_eq("stall_cnt", stall_cnt, s16);
        check_eq("stall_cnt_w3", stall_cnt3, s3);
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.ex    = 4'($urandom);
        b.m     = 3'($urandom);
        b.wb    = 2'($urandom);
        b.rs    = 5'($urandom);
        b.rt    = 5'($urandom);
        b.rd    = 5'($urandom);
        b.rd1   = $urandom;
        b.datab = $urandom;
        b.imm   = $urandom;
        return b;
    endfunction

    task automatic model_update(input logic iv, input beat_t b,
                                input logic ordy, input logic fl);
        bit push;
        bit pop;
        beat_t o;
        push = iv && (mq.size() < 2);
        pop  = (mq.size() > 0) && ordy;
        if (mq.size() > 0 && !ordy) stall_total++;
        if (fl) begin
            mq.delete();
            zero_ctl = 1;
            zero_all = 0;
        end else begin
            if (pop) begin
                o = mq.pop_front();
                if (verbose)
                    $display("[TB] t=%0t out RdE=%0d RD1_E=%0h EX_E=%0h", $time, o.rd, o.rd1, o.ex);
            end
            if (push) begin
                mq.push_back(b);
                zero_ctl = 0;
                zero_all = 0;
            end
        end
    endtask

    task automatic step(input logic iv, input beat_t b, input logic ordy,
                        input logic fl, output bit acc);
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        {EX, M, WB, RsD, RtD, RdD, RD1, DataB, SignImmD} = b;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (mq.size() < 2) && !fl;
        @(posedge clk);
        model_update(iv, b, ordy, fl);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, rand_beat(), ordy, 1'b0, acc);
    endtask

    task automatic send(input beat_t b, input logic ordy);
        bit acc;
        int k;
        acc = 0;
        k = 0;
        while (!acc && k < 20) begin
            step(1'b1, b, ordy, 1'b0, acc);
            k++;
        end
        check_eq("send_accepted", acc, 1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        check_outputs();
        in_valid = 0; out_ready = 0; flush = 0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        stall_total = 0;
        zero_all = 1;
        zero_ctl = 1;
        check_outputs();   // still before the next rising edge
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        bit    acc;
        logic  iv;
        logic  ordy;
        logic  fl;

        n_tests = 0; n_fail = 0;
        verbose = 1;
        stall_total = 0; zero_all = 1; zero_ctl = 1;
        rst_n = 0; in_valid = 0; out_ready = 0; flush = 0;
        {EX, M, WB, RsD, RtD, RdD, RD1, DataB, SignImmD} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1;

        // Pass-through: RD1 = 1,2,3 back to back with out_ready=1
        for (int i = 1; i <= 3; i++) begin
            b = rand_beat(); b.rd1 = i;
            step(1'b1, b, 1'b1, 1'b0, acc);
            check_eq("pass_acc", acc, 1);
        end
        idle(2, 1'b1);

        // Backpressure: A(5), B(6) while stalled, C held until accepted
        b = rand_beat(); b.rd = 5; send(b, 1'b0);
        b = rand_beat(); b.rd = 6; send(b, 1'b0);
        b = rand_beat(); b.rd = 7;
        step(1'b1, b, 1'b0, 1'b0, acc); check_eq("c_blocked", acc, 0);
        step(1'b1, b, 1'b0, 1'b0, acc); check_eq("c_blocked", acc, 0);
        send(b, 1'b1);
        idle(3, 1'b1);

        // Flush while FULL with EX=F in both entries
        b = rand_beat(); b.ex = 4'hF; send(b, 1'b0);
        b = rand_beat(); b.ex = 4'hF; send(b, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b1, acc);
        idle(2, 1'b1);
        // Flush in ONE with a push in the same cycle: the beat is dropped
        b = rand_beat(); b.ex = 4'hF; send(b, 1'b0);
        step(1'b1, rand_beat(), 1'b1, 1'b1, acc);
        idle(2, 1'b1);

        // Counter saturation: one held beat, 10 stalled cycles
        async_reset();
        b = rand_beat(); send(b, 1'b0);
        idle(10, 1'b0);
        idle(2, 1'b1);

        // Async reset while FULL
        b = rand_beat(); send(b, 1'b0);
        b = rand_beat(); send(b, 1'b0);
        async_reset();
        idle(2, 1'b1);

        // Randomised traffic, decode keeps a beat presented until accepted
        verbose = 0;
        b = rand_beat();
        iv = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!iv) begin
                iv = ($urandom_range(0, 9) < 7);
                b = rand_beat();
            end
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 99) < 3);
            step(iv, b, ordy, fl, acc);
            if (acc || fl) iv = 0;
        end
        @(negedge clk);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
